ctrl_trace_decoder: RTL and testbench
=====================================

# ctrl_trace_decoder

Passive consumer of the multicycle datapath control bus. Samples the per-phase control strobes every cycle, reconstructs which instruction class was executed between consecutive `PC_LdEn` pulses, and reports one classification record per retired instruction. Sits beside the datapath, on the receiving end of the control unit's outputs. Used for run-time checking, retirement counting and bench scoreboarding.

## Interface
- `CNT_W`, 16: width of retirement and class counters.
- `MAX_CYC`, 8: window length in cycles at which a missing `PC_LdEn` is a timeout.
- `HALT_ON_ERR`, 0: 1 = freeze in HALT on the first error.
- `Clk`  in  1  single clock; all logic on posedge.
- `Reset`  in  1  synchronous, active-high.
- `PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, MEM_WrEn, Mem_In_Out_Sel`  in  1 each  control strobes, sampled every cycle.
- `ALU_func`  in  4  ALU operation select.
- `Instr_Valid`  out  1  one-cycle pulse per retired instruction.
- `Instr_Class`  out  4  class code, valid with `Instr_Valid`, held otherwise.
- `Instr_Cycles`  out  4  sampled cycles in the window, LdEn cycle included, saturating at 15.
- `Instr_Func`  out  4  last nonzero `ALU_func` seen in the window, else 0.
- `Retired_Cnt`  out  CNT_W  non-ILLEGAL retirements, wraps modulo 2^CNT_W.
- `Err`  out  1  sticky error flag.
- `Err_Code`  out  2  first error: 1 write conflict, 2 double LdEn, 3 timeout.
- `Halted`  out  1  high in HALT.
- `Class_Sel`  in  4  (macro only) histogram read index.
- `Class_Cnt`  out  CNT_W  (macro only) count for `Class_Sel`, combinational read.

## Operation
- States: ACCUM and HALT. Reset → ACCUM with all window flags, counters and outputs cleared.
- ACCUM: OR-accumulate the flags `seen_RF_B`, `seen_WrData`, `seen_WEn`, `seen_BinSel`, `seen_MemWr` and `seen_Byte` each cycle. Also keep the cycle count and the last nonzero `ALU_func`.
- Close the window on a cycle where `PC_LdEn`=1. The classification uses the accumulated flags OR'd with the current cycle's strobes. Then clear the flags and the count for the next window.
- Classification priority, highest first:
  - ILLEGAL (15) if an error was detected in the window.
  - `seen_MemWr`: SB (6) if `seen_Byte`, else SW (5).
  - `seen_WrData`: LB (4) if `seen_Byte`, else LW (3).
  - `seen_WEn`: ALU_I (2) if `seen_BinSel`, else ALU_R (1).
  - `PC_Sel`=1 in the LdEn cycle: BR_T (7).
  - `seen_RF_B`: BR_NT (8).
  - Otherwise NOP (0).
- Errors:
  - Code 1: `RF_WEn` and `MEM_WrEn` both seen in one window.
  - Code 2: `PC_LdEn` high in two consecutive cycles. The second pulse closes a 1-cycle ILLEGAL window.
  - Code 3: the count reaches `MAX_CYC` without `PC_LdEn`. Force-close the window as ILLEGAL with `Instr_Cycles`=`MAX_CYC`, then restart.
- `Err_Code` latches only the first error. `Err` stays high until reset.
- If `HALT_ON_ERR`=1, go to HALT on the error's report edge. HALT ignores all inputs, keeps `Instr_Valid`=0, and is left only by `Reset`.

## Timing
- Record registered: `Instr_Valid` is high for exactly the cycle after the closing sample. Class, cycles, func and counters update on the same edge.
- A new window accumulates starting with the cycle after the closing sample. Back-to-back windows have no dead cycle.
- Reset while a window is open discards it: no record, no count.
- Reset values: all outputs 0. `Instr_Class`=0 (NOP encoding, qualified by `Instr_Valid`=0).
- Timeout and double LdEn in the same cycle: report code 2 (lower code wins).

## Configuration
- `CTRL_DEC_CLASS_HIST_EN` defined:
  - Sixteen CNT_W counters, one per class code, including ILLEGAL.
  - Each increments on its class's `Instr_Valid`; cleared by reset.
  - `Class_Sel`/`Class_Cnt` ports exist.
- Undefined: no counters and no `Class_Sel`/`Class_Cnt` ports. All other behaviour is identical.

## Structure
- Shared package `ctrl_trace_pkg`: 4-bit class code constants (NOP…BR_NT, ILLEGAL) and 2-bit error code constants. The bench scoreboard uses the same package.
- One sub-module, `ctrl_window_acc`: flag accumulation, cycle count with saturation, and last-func capture, with a clear input. The classifier and FSM stay in the top.

## Test plan
- Reset → all outputs 0. Then drive an idle bus for 6 cycles and `PC_LdEn` on cycle 7 → `Instr_Valid` next cycle, class 0, cycles 7, `Retired_Cnt`=1.
- `ALU_func`=4'b0011 on cycle 3, `RF_WEn` on cycle 4, LdEn on cycle 5 → class 1, `Instr_Func`=3.
- `RF_B_sel` on cycles 2-4, `PC_Sel`+LdEn on cycle 5 → class 7. Repeat with `PC_Sel`=0 → class 8.
- `ALU_Bin_sel` then `MEM_WrEn`+`Mem_In_Out_Sel`, then LdEn → class 6. Repeat the load pattern with `RF_WrData_sel`+`RF_WEn` and `Mem_In_Out_Sel`=0 → class 3.
- `RF_WEn` and `MEM_WrEn` in one window → class 15, `Err`=1, `Err_Code`=1, `Retired_Cnt` unchanged. A later timeout leaves `Err_Code` at 1.
- `HALT_ON_ERR`=1, no LdEn for 8 cycles → ILLEGAL record with `Instr_Cycles`=8, `Halted`=1, no further records; `Reset` → ACCUM. With the macro on, after 3 NOPs, `Class_Sel`=0 → `Class_Cnt`=3.

Source files
------------

// File: rtl/ctrl_trace_pkg.sv
// Shared types for the control-bus trace decoder: class codes, error codes,
// decoder state and the per-window strobe flag bundle.
package ctrl_trace_pkg;

   localparam int unsigned CLASS_W     = 4;
   localparam int unsigned ERR_W       = 2;
   localparam int unsigned FUNC_W      = 4;
   localparam int unsigned CYC_W       = 4;
   localparam int unsigned NUM_CLASSES = 16;

   typedef enum logic [CLASS_W-1:0] {
      CLS_NOP     = 4'd0,
      CLS_ALU_R   = 4'd1,
      CLS_ALU_I   = 4'd2,
      CLS_LW      = 4'd3,
      CLS_LB      = 4'd4,
      CLS_SW      = 4'd5,
      CLS_SB      = 4'd6,
      CLS_BR_T    = 4'd7,
      CLS_BR_NT   = 4'd8,
      CLS_ILLEGAL = 4'd15
   } instr_class_e;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE        = 2'd0,
      ERR_WR_CONFLICT = 2'd1,
      ERR_DOUBLE_LDEN = 2'd2,
      ERR_TIMEOUT     = 2'd3
   } err_code_e;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HALT  = 1'b1
   } dec_state_e;

   // Strobes that are OR-accumulated across one instruction window
   typedef struct packed {
      logic rf_b;
      logic wr_data;
      logic wen;
      logic bin_sel;
      logic mem_wr;
      logic byte_sel;
   } win_flags_t;

   // Saturating increment for the window cycle counter
   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (v == '1) ? v : v + CYC_W'(1);
   endfunction

endpackage

// File: rtl/ctrl_window_acc.sv
// Instruction-window accumulator: sticky strobe flags, saturating cycle count
// and last nonzero ALU function. The _c outputs already fold in the current
// cycle so the closing sample is part of the window it closes.
module ctrl_window_acc
   import ctrl_trace_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clr,
   input  win_flags_t        strobes,
   input  logic [FUNC_W-1:0] func,
   output win_flags_t        flags_c,
   output logic [CYC_W-1:0]  cycles_c,
   output logic [FUNC_W-1:0] func_c
);

   win_flags_t        flags_q;
   logic [CYC_W-1:0]  cnt_q;
   logic [FUNC_W-1:0] func_q;

   // Window view including the current cycle
   always_comb begin
      flags_c  = win_flags_t'(flags_q | strobes);
      cycles_c = sat_inc(cnt_q);
      func_c   = (func != '0) ? func : func_q;
   end

   // Accumulate, or start empty on the cycle after a close
   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         flags_q <= '0;
         cnt_q   <= '0;
         func_q  <= '0;
      end else begin
         flags_q <= flags_c;
         cnt_q   <= cycles_c;
         func_q  <= func_c;
      end
   end

endmodule

// File: rtl/ctrl_trace_decoder.sv
// Passive decoder of the multicycle control bus. Emits one registered
// classification record per PC_LdEn-delimited instruction window, counts
// retirements and flags protocol errors.
// Optional feature: define CTRL_DEC_CLASS_HIST_EN for per-class counters
// readable through Class_Sel / Class_Cnt.
// MAX_CYC must lie in 1..15 so the saturating window count can reach it.
module ctrl_trace_decoder
   import ctrl_trace_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MAX_CYC     = 8,
   parameter int unsigned HALT_ON_ERR = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              PC_Sel,
   input  logic              PC_LdEn,
   input  logic              RF_B_sel,
   input  logic              RF_WrData_sel,
   input  logic              RF_WEn,
   input  logic              ALU_Bin_sel,
   input  logic              MEM_WrEn,
   input  logic              Mem_In_Out_Sel,
   input  logic [FUNC_W-1:0] ALU_func,
`ifdef CTRL_DEC_CLASS_HIST_EN
   input  logic [CLASS_W-1:0] Class_Sel,
   output logic [CNT_W-1:0]   Class_Cnt,
`endif
   output logic               Instr_Valid,
   output logic [CLASS_W-1:0] Instr_Class,
   output logic [CYC_W-1:0]   Instr_Cycles,
   output logic [FUNC_W-1:0]  Instr_Func,
   output logic [CNT_W-1:0]   Retired_Cnt,
   output logic               Err,
   output logic [ERR_W-1:0]   Err_Code,
   output logic               Halted
);

   dec_state_e        state_q;
   logic              prev_lden_q;
   win_flags_t        strobes;
   win_flags_t        eff;
   logic [CYC_W-1:0]  cyc_c;
   logic [FUNC_W-1:0] func_c;
   logic              acc_clr_c;
   logic              double_c;
   logic              conflict_c;
   logic              timeout_c;
   logic              close_c;
   logic              err_c;
   err_code_e         err_code_c;
   instr_class_e      class_c;

   // Strobe bundle seen by the accumulator
   always_comb begin
      strobes          = '0;
      strobes.rf_b     = RF_B_sel;
      strobes.wr_data  = RF_WrData_sel;
      strobes.wen      = RF_WEn;
      strobes.bin_sel  = ALU_Bin_sel;
      strobes.mem_wr   = MEM_WrEn;
      strobes.byte_sel = Mem_In_Out_Sel;
   end

   // Window is emptied after every close and held empty while halted
   assign acc_clr_c = close_c || (state_q == ST_HALT);

   ctrl_window_acc u_acc (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (acc_clr_c),
      .strobes  (strobes),
      .func     (ALU_func),
      .flags_c  (eff),
      .cycles_c (cyc_c),
      .func_c   (func_c)
   );

   // Close detection, error detection and class priority for this window
   always_comb begin
      double_c   = PC_LdEn && prev_lden_q;
      conflict_c = eff.wen && eff.mem_wr;
      timeout_c  = !PC_LdEn && (32'(cyc_c) >= MAX_CYC);
      close_c    = (state_q == ST_ACCUM) && (PC_LdEn || timeout_c);
      err_c      = conflict_c || double_c || timeout_c;

      err_code_c = ERR_NONE;
      if (conflict_c)     err_code_c = ERR_WR_CONFLICT;
      else if (double_c)  err_code_c = ERR_DOUBLE_LDEN;
      else if (timeout_c) err_code_c = ERR_TIMEOUT;

      class_c = CLS_NOP;
      if (err_c) begin
         class_c = CLS_ILLEGAL;
      end else if (eff.mem_wr) begin
         if (eff.byte_sel) class_c = CLS_SB;
         else              class_c = CLS_SW;
      end else if (eff.wr_data) begin
         if (eff.byte_sel) class_c = CLS_LB;
         else              class_c = CLS_LW;
      end else if (eff.wen) begin
         if (eff.bin_sel)  class_c = CLS_ALU_I;
         else              class_c = CLS_ALU_R;
      end else if (PC_Sel) begin
         class_c = CLS_BR_T;
      end else if (eff.rf_b) begin
         class_c = CLS_BR_NT;
      end
   end

   // ACCUM/HALT state machine with the registered record and status outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_ACCUM;
         prev_lden_q  <= 1'b0;
         Instr_Valid  <= 1'b0;
         Instr_Class  <= CLS_NOP;
         Instr_Cycles <= '0;
         Instr_Func   <= '0;
         Retired_Cnt  <= '0;
         Err          <= 1'b0;
         Err_Code     <= ERR_NONE;
         Halted       <= 1'b0;
      end else begin
         Instr_Valid <= 1'b0;
         case (state_q)
            ST_ACCUM: begin
               prev_lden_q <= PC_LdEn;
               if (close_c) begin
                  Instr_Valid  <= 1'b1;
                  Instr_Class  <= class_c;
                  Instr_Cycles <= cyc_c;
                  Instr_Func   <= func_c;
                  if (!err_c) begin
                     Retired_Cnt <= Retired_Cnt + CNT_W'(1);
                  end else begin
                     Err <= 1'b1;
                     if (!Err) Err_Code <= err_code_c;
                     if (HALT_ON_ERR != 0) begin
                        state_q <= ST_HALT;
                        Halted  <= 1'b1;
                     end
                  end
               end
            end
            ST_HALT: begin
               Halted <= 1'b1;
            end
            default: begin
               state_q <= ST_ACCUM;
            end
         endcase
      end
   end

`ifdef CTRL_DEC_CLASS_HIST_EN
   logic [CNT_W-1:0] hist_q [NUM_CLASSES];

   // Per-class record counters, bumped on the record edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hist_q <= '{default: '0};
      end else if (close_c) begin
         hist_q[class_c] <= hist_q[class_c] + CNT_W'(1);
      end
   end

   assign Class_Cnt = hist_q[Class_Sel];
`endif

endmodule

// File: tb/tb_ctrl_trace_decoder.sv
// Bench for ctrl_trace_decoder: two instances (HALT_ON_ERR 0 and 1) share the
// control bus; a window-queue scoreboard predicts every output each cycle and
// directed literal checks pin the scoreboard.
module tb_ctrl_trace_decoder;
   import ctrl_trace_pkg::*;

   localparam int MAXC = 8;

   localparam logic [7:0] SEL = 8'h80;
   localparam logic [7:0] LD  = 8'h40;
   localparam logic [7:0] RFB = 8'h20;
   localparam logic [7:0] WD  = 8'h10;
   localparam logic [7:0] WEN = 8'h08;
   localparam logic [7:0] BIN = 8'h04;
   localparam logic [7:0] MW  = 8'h02;
   localparam logic [7:0] BYT = 8'h01;

   logic Clk;
   logic rst0, rst1;
   logic PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, MEM_WrEn, Mem_In_Out_Sel;
   logic [3:0] ALU_func;

   logic        o_valid [2];
   logic [3:0]  o_class [2];
   logic [3:0]  o_cyc   [2];
   logic [3:0]  o_func  [2];
   logic [15:0] o_ret   [2];
   logic        o_err   [2];
   logic [1:0]  o_code  [2];
   logic        o_halt  [2];
`ifdef CTRL_DEC_CLASS_HIST_EN
   logic [3:0]  class_sel;
   logic [15:0] o_hcnt  [2];
`endif

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 0;

   ctrl_trace_decoder #(.CNT_W(16), .MAX_CYC(MAXC), .HALT_ON_ERR(0)) dut0 (
      .Clk(Clk), .Reset(rst0),
      .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel),
      .RF_WEn(RF_WEn), .ALU_Bin_sel(ALU_Bin_sel), .MEM_WrEn(MEM_WrEn), .Mem_In_Out_Sel(Mem_In_Out_Sel),
      .ALU_func(ALU_func),
`ifdef CTRL_DEC_CLASS_HIST_EN
      .Class_Sel(class_sel), .Class_Cnt(o_hcnt[0]),
`endif
      .Instr_Valid(o_valid[0]), .Instr_Class(o_class[0]), .Instr_Cycles(o_cyc[0]),
      .Instr_Func(o_func[0]), .Retired_Cnt(o_ret[0]), .Err(o_err[0]), .Err_Code(o_code[0]),
      .Halted(o_halt[0])
   );

   ctrl_trace_decoder #(.CNT_W(16), .MAX_CYC(MAXC), .HALT_ON_ERR(1)) dut1 (
      .Clk(Clk), .Reset(rst1),
      .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel),
      .RF_WEn(RF_WEn), .ALU_Bin_sel(ALU_Bin_sel), .MEM_WrEn(MEM_WrEn), .Mem_In_Out_Sel(Mem_In_Out_Sel),
      .ALU_func(ALU_func),
`ifdef CTRL_DEC_CLASS_HIST_EN
      .Class_Sel(class_sel), .Class_Cnt(o_hcnt[1]),
`endif
      .Instr_Valid(o_valid[1]), .Instr_Class(o_class[1]), .Instr_Cycles(o_cyc[1]),
      .Instr_Func(o_func[1]), .Retired_Cnt(o_ret[1]), .Err(o_err[1]), .Err_Code(o_code[1]),
      .Halted(o_halt[1])
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string nm, input int k, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic sel, ld, rfb, wd, wen, bin, mw, byt;
      logic [3:0] fn;
   } smp_t;

   smp_t        win [2][16];
   int          wlen   [2];
   logic        m_valid[2];
   logic [3:0]  m_class[2];
   logic [3:0]  m_cyc  [2];
   logic [3:0]  m_func [2];
   logic [15:0] m_ret  [2];
   logic        m_err  [2];
   logic [1:0]  m_code [2];
   logic        m_halt [2];
   logic        m_prev [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         wlen[k] = 0; m_valid[k] = 0; m_class[k] = 0; m_cyc[k] = 0; m_func[k] = 0;
         m_ret[k] = 0; m_err[k] = 0; m_code[k] = 0; m_halt[k] = 0; m_prev[k] = 0;
      end
   end

   // Record predicted from the whole list of samples in the current window
   always @(posedge Clk) begin
      smp_t s;
      logic rst, dbl, tmo, conf, err;
      logic a_rfb, a_wd, a_wen, a_bin, a_mw, a_byt;
      logic [3:0] lastfn, cls;
      s = {PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, MEM_WrEn, Mem_In_Out_Sel, ALU_func};
      for (int k = 0; k < 2; k++) begin
         rst = (k == 0) ? rst0 : rst1;
         if (rst) begin
            wlen[k] = 0; m_valid[k] = 0; m_class[k] = 0; m_cyc[k] = 0; m_func[k] = 0;
            m_ret[k] = 0; m_err[k] = 0; m_code[k] = 0; m_halt[k] = 0; m_prev[k] = 0;
         end else if (m_halt[k]) begin
            m_valid[k] = 0;
         end else begin
            m_valid[k] = 0;
            win[k][wlen[k]] = s;
            wlen[k]++;
            dbl = s.ld && m_prev[k];
            tmo = !s.ld && (wlen[k] >= MAXC);
            if (s.ld || tmo) begin
               {a_rfb, a_wd, a_wen, a_bin, a_mw, a_byt} = '0;
               lastfn = 4'd0;
               for (int i = 0; i < wlen[k]; i++) begin
                  a_rfb |= win[k][i].rfb; a_wd |= win[k][i].wd; a_wen |= win[k][i].wen;
                  a_bin |= win[k][i].bin; a_mw |= win[k][i].mw; a_byt |= win[k][i].byt;
                  if (win[k][i].fn != 4'd0) lastfn = win[k][i].fn;
               end
               conf = a_wen && a_mw;
               err  = conf || dbl || tmo;
               if (err)        cls = CLS_ILLEGAL;
               else if (a_mw)  cls = a_byt ? CLS_SB : CLS_SW;
               else if (a_wd)  cls = a_byt ? CLS_LB : CLS_LW;
               else if (a_wen) cls = a_bin ? CLS_ALU_I : CLS_ALU_R;
               else if (s.sel) cls = CLS_BR_T;
               else if (a_rfb) cls = CLS_BR_NT;
               else            cls = CLS_NOP;
               m_valid[k] = 1;
               m_class[k] = cls;
               m_cyc[k]   = 4'((wlen[k] > 15) ? 15 : wlen[k]);
               m_func[k]  = lastfn;
               if (!err) m_ret[k] = m_ret[k] + 16'd1;
               else begin
                  if (!m_err[k]) m_code[k] = conf ? 2'd1 : (dbl ? 2'd2 : 2'd3);
                  m_err[k] = 1;
                  if (k == 1) m_halt[k] = 1;
               end
               wlen[k] = 0;
            end
            m_prev[k] = s.ld;
         end
      end
   end

   // Every-cycle comparison of both instances against the scoreboard
   always @(negedge Clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check("valid",   k, o_valid[k], m_valid[k]);
            check("class",   k, o_class[k], m_class[k]);
            check("cycles",  k, o_cyc[k],   m_cyc[k]);
            check("func",    k, o_func[k],  m_func[k]);
            check("retired", k, o_ret[k],   m_ret[k]);
            check("err",     k, o_err[k],   m_err[k]);
            check("errcode", k, o_code[k],  m_code[k]);
            check("halted",  k, o_halt[k],  m_halt[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [7:0] b, input logic [3:0] fn);
      {PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, MEM_WrEn, Mem_In_Out_Sel} = b;
      ALU_func = fn;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(8'h00, 4'd0);
   endtask

   task automatic rec0(input string nm, input int cls, input int cycles, input int ret);
      check({nm, "_valid"},   0, o_valid[0], 1);
      check({nm, "_class"},   0, o_class[0], cls);
      check({nm, "_cycles"},  0, o_cyc[0],   cycles);
      check({nm, "_retired"}, 0, o_ret[0],   ret);
   endtask

   initial begin
      {PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, MEM_WrEn, Mem_In_Out_Sel} = '0;
      ALU_func = 4'd0;
`ifdef CTRL_DEC_CLASS_HIST_EN
      class_sel = 4'd0;
`endif
      rst0 = 1; rst1 = 1;
      @(negedge Clk);
      idle(2);
      rst0 = 0; rst1 = 0;
      chk_en = 1;
      check("rst_valid", 0, o_valid[0], 0);
      check("rst_class", 0, o_class[0], 0);
      check("rst_ret",   0, o_ret[0],   0);
      check("rst_err",   0, {o_err[0], o_code[0], o_halt[0]}, 0);

      // idle window closed on cycle 7
      idle(6);
      check("idle_novalid", 0, o_valid[0], 0);
      cyc(LD, 4'd0);
      rec0("nop", 0, 7, 1);

      // ALU_R with function capture
      idle(2); cyc(8'h00, 4'd3); cyc(WEN, 4'd0); cyc(LD, 4'd0);
      rec0("alur", 1, 5, 2);
      check("alur_func", 0, o_func[0], 3);

      // taken / not-taken branches
      idle(1); cyc(RFB, 4'd0); cyc(RFB, 4'd0); cyc(RFB, 4'd0); cyc(SEL | LD, 4'd0);
      rec0("brt", 7, 5, 3);
      idle(1); cyc(RFB, 4'd0); cyc(RFB, 4'd0); cyc(RFB, 4'd0); cyc(LD, 4'd0);
      rec0("brnt", 8, 5, 4);

      // stores / loads / ALU_I
      cyc(BIN, 4'd0); cyc(MW | BYT, 4'd0); cyc(LD, 4'd0);
      rec0("sb", 6, 3, 5);
      cyc(BIN, 4'd0); cyc(WD | WEN, 4'd0); cyc(LD, 4'd0);
      rec0("lw", 3, 3, 6);
      cyc(WD | WEN | BYT, 4'd0); cyc(LD, 4'd0);
      rec0("lb", 4, 2, 7);
      idle(1); cyc(WEN | BIN | LD, 4'd5);
      rec0("alui", 2, 2, 8);
      check("alui_func", 0, o_func[0], 5);
      cyc(MW, 4'd0); cyc(LD, 4'd0);
      rec0("sw", 5, 2, 9);

      // write conflict; halting instance freezes
      cyc(WEN, 4'd0); cyc(MW, 4'd0); cyc(LD, 4'd0);
      rec0("conf", 15, 3, 9);
      check("conf_err",  0, o_err[0],  1);
      check("conf_code", 0, o_code[0], 1);
      check("conf_halt", 1, o_halt[1], 1);
      check("conf_nohalt", 0, o_halt[0], 0);

      // double LdEn: second pulse is a 1-cycle ILLEGAL window
      idle(1); cyc(LD, 4'd0);
      rec0("dbl_first", 0, 2, 10);
      cyc(LD, 4'd0);
      rec0("dbl", 15, 1, 10);
      check("dbl_code", 0, o_code[0], 1);

      // timeout after 8 cycles keeps first error code
      idle(7);
      check("to_early", 0, o_valid[0], 0);
      idle(1);
      rec0("to", 15, 8, 10);
      check("to_code", 0, o_code[0], 1);
      check("halt_silent", 1, o_valid[1], 0);

      // halting instance: reset, timeout, freeze, reset again
      rst1 = 1; idle(1); rst1 = 0;
      check("h_rst", 1, o_halt[1], 0);
      idle(7);
      check("h_early", 1, o_valid[1], 0);
      idle(1);
      check("h_valid",  1, o_valid[1], 1);
      check("h_class",  1, o_class[1], 15);
      check("h_cycles", 1, o_cyc[1],   8);
      check("h_code",   1, o_code[1],  3);
      check("h_halt",   1, o_halt[1],  1);
      cyc(LD, 4'd0);
      check("h_frozen", 1, o_valid[1], 0);
      rst1 = 1; idle(1); rst1 = 0;
      check("h_unhalt", 1, o_halt[1], 0);
      cyc(LD, 4'd0); idle(1); cyc(LD, 4'd0); idle(1); cyc(LD, 4'd0);
      check("h_ret", 1, o_ret[1], 3);
`ifdef CTRL_DEC_CLASS_HIST_EN
      class_sel = 4'd0;
      #1;
      check("hist_nop", 1, o_hcnt[1], 3);
`endif

      // reset mid-window discards the partial instruction
      idle(1);
      cyc(WEN, 4'd0); cyc(WEN, 4'd0);
      rst0 = 1; rst1 = 1; idle(1); rst0 = 0; rst1 = 0;
      cyc(LD, 4'd0);
      rec0("rst_mid", 0, 1, 1);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
